spi_slave_fifo_mm: RTL
======================

Name: spi_slave_fifo_mm

Overview:
- Parametrised SPI slave with memory-mapped host interface.
- Oversamples the external SPI pins into the single system clock domain and deserialises MOSI frames into an RX FIFO.
- Serialises host-written words from a TX FIFO onto MISO.
- Exposes data, status and control registers on a 2-bit address bus with a level interrupt; supports all four SPI modes and configurable word width and FIFO depths.

Parameters:
DATA_WIDTH, 8, bits per SPI frame; legal 4..32; MSB first.
RX_DEPTH_LOG2, 10, log2 of RX FIFO depth (1024 words).
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 words).
CPOL, 0, idle level of scl.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
SYNC_STAGES, 2, synchroniser flops on scl, mosi, ss_n; minimum 2.

Ports:
clk  input  1  system clock; must be at least 4x scl frequency.
reset_n  input  1  asynchronous, active-low reset.
address  input  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
read  input  1  host read strobe, one cycle per access.
write  input  1  host write strobe, one cycle per access.
writedata  input  32  host write data.
readdata  output  32  host read data; registered, valid 1 cycle after read.
irq  output  1  registered level interrupt.
scl  input  1  SPI clock, asynchronous to clk.
mosi  input  1  SPI data in.
ss_n  input  1  SPI select, active-low.
miso  output  1  SPI data out; driven 0 while ss_n is high.

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, all sticky flags 0, CONTROL 0, bit counter 0. Outputs readdata, irq and miso are 0.
- Pin sync and edge detection:
  - scl, mosi and ss_n each pass through SYNC_STAGES flops. Edges are detected on the synchronised scl.
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - The sample edge is the leading edge if CPHA=0, otherwise the trailing edge. The shift edge is the other edge.
- Receive:
  - On each sample edge with synchronised ss_n low, shift mosi into the RX shift register (LSB in) and increment the bit counter.
  - When the count reaches DATA_WIDTH, push the word into the RX FIFO on the next clk and reset the counter to 0.
  - Pin-to-FIFO latency: at most SYNC_STAGES+3 clk cycles after the final sample edge.
- Framing: ss_n rising mid-frame discards the partial word and clears the counter; nothing is pushed.
- RX full:
  - A push is accepted if the FIFO is not full, or if a host pop occurs in the same cycle.
  - Otherwise the word is dropped and rx_overflow is set (sticky).
- Transmit:
  - At frame start (synchronised ss_n falling, or counter returning to 0 while ss_n is low), pop the TX FIFO into the TX shift register.
  - If the TX FIFO is empty, load 0 and set tx_underrun (sticky).
  - miso = TX shift MSB while ss_n is low. The register shifts left on each shift edge.
  - CPHA=0: MSB is valid before the first sample edge. CPHA=1: the first shift edge is skipped.
- DATA register (address 0):
  - Read pops the RX FIFO and returns the word zero-extended to 32 bits.
  - Read when empty returns 0, causes no pop and sets no flag.
  - Write pushes writedata[DATA_WIDTH-1:0] into the TX FIFO. If TX is full, the write is dropped and tx_overflow is set (sticky).
- STATUS register (address 1), read-only except for write-1-to-clear on bits 2, 4 and 5:
  - bit0 rx_empty, bit1 rx_full, bit2 rx_overflow, bit3 tx_empty, bit4 tx_underrun, bit5 tx_overflow, bit6 frame_active (synchronised ~ss_n).
  - bits[31:16] rx_level, zero-extended.
  - If a sticky set and a W1C clear hit the same cycle, set wins.
- CONTROL register (address 2), read/write:
  - bit0 irq_rx_nonempty_en, bit1 irq_error_en.
  - bit2 rx_flush: self-clearing, empties the RX FIFO in 1 cycle. Sticky flags are untouched. A push in the same cycle is discarded.
  - bit3 tx_flush: same behaviour for the TX FIFO.
- Address 3: reads 0, writes ignored.
- FIFO pointers: wrap modulo depth. Level is computed from pointers with one extra MSB so full and empty are distinct. Simultaneous push and pop leaves the level unchanged.
- irq, registered: (bit0 & ~rx_empty) | (bit1 & (rx_overflow | tx_underrun | tx_overflow)).
- Simultaneous read and write in one cycle: both take effect.

Test Plan:
- Mode 0, DATA_WIDTH=8: send 0xA5, 0x3C -> STATUS rx_level=2; DATA reads return 0xA5 then 0x3C; then rx_empty=1.
- Each of the 4 modes: pre-write TX 0x81, master sends 0x7E -> master receives 0x81 and host reads 0x7E; tx_empty=1 afterwards.
- RX_DEPTH_LOG2=2: send 5 frames with no reads -> rx_full=1, rx_overflow=1, reads return frames 1-4 only; W1C 0x4 clears overflow.
- ss_n raised after 5 of 8 bits, then full frame 0x11 sent -> exactly one word, 0x11, in the FIFO.
- Empty TX, master clocks 1 frame -> miso all 0, tx_underrun=1; with CONTROL=0x2, irq rises within 2 clk.
- Assert reset_n low mid-frame with 3 words queued -> all outputs 0 immediately; after release, STATUS reads 0x0000_0009.

Source files
------------

// File: rtl/spi_slave_fifo_mm.sv
// rtl/spi_slave_fifo_mm.sv - SPI slave with RX/TX FIFOs and a memory-mapped register interface
module spi_slave_fifo_mm #(
    parameter int DATA_WIDTH    = 8,
    parameter int RX_DEPTH_LOG2 = 10,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int CPOL          = 0,
    parameter int CPHA          = 0,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        scl,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso
);
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic CPOL_B = (CPOL != 0);
    localparam logic CPHA_B = (CPHA != 0);

    logic [SYNC_STAGES-1:0] scl_sync, mosi_sync, ss_sync;
    logic                   scl_prev, ss_prev;
    logic                   scl_s, mosi_s, ss_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync  <= {SYNC_STAGES{CPOL_B}};
            mosi_sync <= '0;
            ss_sync   <= '1;
            scl_prev  <= CPOL_B;
            ss_prev   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            scl_prev  <= scl_s;
            ss_prev   <= ss_s;
        end
    end

    assign scl_s  = scl_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    logic scl_rise, scl_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_active, ss_fall;
    assign scl_rise    = scl_s & ~scl_prev;
    assign scl_fall    = ~scl_s & scl_prev;
    assign lead_edge   = CPOL_B ? scl_fall : scl_rise;
    assign trail_edge  = CPOL_B ? scl_rise : scl_fall;
    assign sample_edge = CPHA_B ? trail_edge : lead_edge;
    assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
    assign ss_active   = ~ss_s;
    assign ss_fall     = ~ss_s & ss_prev;

    // Host decode
    logic wr_data, rd_data, wr_status, wr_ctrl, rx_flush, tx_flush;
    assign wr_data   = write && (address == 2'd0);
    assign rd_data   = read && (address == 2'd0);
    assign wr_status = write && (address == 2'd1);
    assign wr_ctrl   = write && (address == 2'd2);
    assign rx_flush  = wr_ctrl && writedata[2];
    assign tx_flush  = wr_ctrl && writedata[3];

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [RX_DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr, rx_level;
    logic [TX_DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr, tx_level;
    logic rx_empty, rx_full, tx_empty, tx_full;

    assign rx_level = rx_wr_ptr - rx_rd_ptr;
    assign tx_level = tx_wr_ptr - tx_rd_ptr;
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == (RX_DEPTH_LOG2+1)'(RX_DEPTH));
    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == (TX_DEPTH_LOG2+1)'(TX_DEPTH));

    logic [DATA_WIDTH-1:0] rx_shift, tx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done, tx_load;
    logic                  rx_pop, rx_push, rx_ovf_set, tx_push, tx_pop, tx_ovf_set, tx_unf_set;

    assign word_done  = (bit_cnt == CNT_W'(DATA_WIDTH));
    assign tx_load    = ss_active && (ss_fall || word_done);
    assign rx_pop     = rd_data && !rx_empty && !rx_flush;
    assign rx_push    = word_done && (!rx_full || rx_pop) && !rx_flush;
    assign rx_ovf_set = word_done && rx_full && !rx_pop && !rx_flush;
    assign tx_push    = wr_data && !tx_full && !tx_flush;
    assign tx_ovf_set = wr_data && tx_full && !tx_flush;
    assign tx_pop     = tx_load && !tx_empty && !tx_flush;
    assign tx_unf_set = tx_load && tx_empty;

    // A shift edge at count 0 is skipped: in CPHA=1 it precedes the first
    // sample, in CPHA=0 it trails the last sample after the next word loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            if (word_done || !ss_active) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (tx_load) begin
                tx_shift <= tx_empty ? '0 : tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
            end else if (shift_edge && ss_active && (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign miso = ss_active & tx_shift[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_shift;
        if (tx_push) tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= writedata[DATA_WIDTH-1:0];
    end

    logic       rx_ovf, tx_unf, tx_ovf;
    logic [1:0] ctrl;
    logic [31:0] status;

    assign status = {16'(rx_level), 9'b0, ss_active, tx_ovf, tx_unf, tx_empty,
                     rx_ovf, rx_full, rx_empty};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_ovf    <= 1'b0;
            tx_unf    <= 1'b0;
            tx_ovf    <= 1'b0;
            ctrl      <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            // Set beats a simultaneous write-1-to-clear
            rx_ovf <= rx_ovf_set | (rx_ovf & ~(wr_status & writedata[2]));
            tx_unf <= tx_unf_set | (tx_unf & ~(wr_status & writedata[4]));
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_status & writedata[5]));
            if (wr_ctrl) ctrl <= writedata[1:0];
            if (read) begin
                case (address)
                    2'd0:    readdata <= rx_empty ? 32'd0
                                       : 32'(rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]]);
                    2'd1:    readdata <= status;
                    2'd2:    readdata <= {30'd0, ctrl};
                    default: readdata <= 32'd0;
                endcase
            end
            irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & (rx_ovf | tx_unf | tx_ovf));
        end
    end
endmodule
